// File: rtl/parallel_recv.sv
`default_nettype none
// ============================================================================
//  Module   : parallel_recv
//  Brief    : 32-bit parallel link test-pattern receiver. Locks the word
//             rotation on the align pattern, then checks incrementing words.
//  Revision : 1.0  initial release
// ============================================================================
module parallel_recv #(
  parameter logic [31:0] ALIGN_PAT = 32'hF731_8CEF,
  parameter int          DATA_LEN  = 1024,
  parameter int          ERR_W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             PHY_INIT,
  input  logic             DIVALID,
  input  logic [31:0]      DIN,
  output logic             ALIGNED,
  output logic [4:0]       ROT,
  output logic             DOVALID,
  output logic [31:0]      DOUT,
  output logic             ERR,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [ERR_W-1:0] BLK_CNT
);

  localparam int                  c_WCNT_W = $clog2(DATA_LEN) + 1;
  localparam logic [c_WCNT_W-1:0] c_LAST   = c_WCNT_W'(DATA_LEN - 1);
  localparam logic                c_ONE    = (DATA_LEN == 1);

  typedef enum logic [1:0] {
    S_HUNT  = 2'd0,
    S_ALIGN = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_aligned;
  logic [4:0]          r_rot;
  logic                r_dovalid;
  logic [31:0]         r_dout;
  logic                r_err;
  logic [ERR_W-1:0]    r_err_cnt;
  logic [ERR_W-1:0]    r_blk_cnt;
  logic [31:0]         r_exp;
  logic [c_WCNT_W-1:0] r_wcnt;

  // Doubling the word turns any right rotation into a plain part-select.
  logic [63:0] w_dd;
  logic [31:0] w_word;
  logic        w_hit;
  logic [4:0]  w_hit_k;

  assign w_dd   = {DIN, DIN};
  assign w_word = w_dd[r_rot +: 32];

  always_comb begin
    w_hit   = 1'b0;
    w_hit_k = 5'd0;
    for (int k = 0; k < 32; k++) begin
      if (!w_hit && (w_dd[k +: 32] == ALIGN_PAT)) begin
        w_hit   = 1'b1;
        w_hit_k = 5'(k);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= S_HUNT;
      r_aligned <= 1'b0;
      r_rot     <= '0;
      r_dovalid <= 1'b0;
      r_dout    <= '0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
      r_blk_cnt <= '0;
      r_exp     <= '0;
      r_wcnt    <= '0;
    end else if (CLR) begin
      r_state   <= S_HUNT;
      r_aligned <= 1'b0;
      r_rot     <= '0;
      r_dovalid <= 1'b0;
      r_dout    <= '0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
      r_blk_cnt <= '0;
      r_exp     <= '0;
      r_wcnt    <= '0;
    end else if (PHY_INIT) begin
      r_state   <= S_HUNT;
      r_aligned <= 1'b0;
      r_dovalid <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_dovalid <= 1'b0;
      r_err     <= 1'b0;
      if (DIVALID) begin
        case (r_state)
          S_HUNT: begin
            if (w_hit) begin
              r_rot     <= w_hit_k;
              r_aligned <= 1'b1;
              r_state   <= S_ALIGN;
            end
          end
          S_ALIGN: begin
            // Repeated align words are tolerated; the first other word starts the block.
            if (w_word != ALIGN_PAT) begin
              r_dout    <= w_word;
              r_dovalid <= 1'b1;
              r_exp     <= w_word + 32'd1;
              r_wcnt    <= c_WCNT_W'(1);
              if (c_ONE) begin
                r_blk_cnt <= r_blk_cnt + 1'b1;
                r_aligned <= 1'b0;
                r_state   <= S_HUNT;
              end else begin
                r_state   <= S_CHECK;
              end
            end
          end
          S_CHECK: begin
            r_dout    <= w_word;
            r_dovalid <= 1'b1;
            r_exp     <= r_exp + 32'd1;
            r_wcnt    <= r_wcnt + 1'b1;
            if (w_word != r_exp) begin
              r_err <= 1'b1;
              if (r_err_cnt != {ERR_W{1'b1}})
                r_err_cnt <= r_err_cnt + 1'b1;
            end
            if (r_wcnt == c_LAST) begin
              r_blk_cnt <= r_blk_cnt + 1'b1;
              r_aligned <= 1'b0;
              r_state   <= S_HUNT;
            end
          end
          default: begin
            r_state   <= S_HUNT;
            r_aligned <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ALIGNED = r_aligned;
  assign ROT     = r_rot;
  assign DOVALID = r_dovalid;
  assign DOUT    = r_dout;
  assign ERR     = r_err;
  assign ERR_CNT = r_err_cnt;
  assign BLK_CNT = r_blk_cnt;

endmodule
`default_nettype wire
